// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller: floor-count defaults, the
// direction encoding shared with the lift FSM, the scheduler state enum and the
// SCAN priority-search helpers.
package lift_pkg;

    localparam int unsigned NUM_FLOORS = 9;
    localparam int unsigned FLOOR_W    = 4;

    // Movement encoding, shared with the lift FSM.
    localparam logic [1:0] DIR_IDLE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // Search helpers work on a fixed maximum width; callers zero-extend.
    localparam int unsigned MAX_FLOORS = 32;
    localparam int unsigned MAX_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN
    } state_e;

    typedef struct packed {
        logic             found;
        logic [MAX_W-1:0] idx;
    } search_t;

    // Lowest set bit strictly above cur.
    function automatic search_t lowest_above(input logic [MAX_FLOORS-1:0] req,
                                             input logic [MAX_W-1:0]      cur);
        search_t res;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (!res.found && req[i] && (MAX_W'(i) > cur)) begin
                res.found = 1'b1;
                res.idx   = MAX_W'(i);
            end
        end
        return res;
    endfunction

    // Highest set bit strictly below cur.
    function automatic search_t highest_below(input logic [MAX_FLOORS-1:0] req,
                                              input logic [MAX_W-1:0]      cur);
        search_t res;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (req[i] && (MAX_W'(i) < cur)) begin
                res.found = 1'b1;
                res.idx   = MAX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on each accepted released->pressed (1->0) level change.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   key_i        raw active-low key
//   press_evt_o  one-cycle pulse per debounced press
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_evt_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            key_s1_q, key_s2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (key_s2_q != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                // Only the released->pressed edge is an event.
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            level_q  <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            key_s1_q <= key_i;
            key_s2_q <= key_s1_q;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_evt_o = press_q;

endmodule

// File: rtl/lift_request_scheduler.sv
// Lift request scheduler: captures debounced one-hot floor requests into a
// pending bitmap, clears them as the lift services floors, and picks the next
// target with a SCAN (keep-direction) policy.
// Ports:
//   CLOCK_50, Reset         clock, asynchronous active-high reset
//   SW, KEY0                raw one-hot floor switches, raw active-low request key
//   cur_floor, at_floor     lift position and doors-open-at-floor status
//   pending                 outstanding request bitmap
//   target_floor/valid      next floor to serve
//   direction               0 idle, 1 up, 2 down
//   req_accept, req_reject  one-cycle request outcome pulses
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = lift_pkg::NUM_FLOORS,
    parameter int unsigned FLOOR_W         = lift_pkg::FLOOR_W,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] SW,
    input  logic                  KEY0,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  at_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic [1:0]            direction,
    output logic                  req_accept,
    output logic                  req_reject
);

    logic                  press_evt;
    logic [NUM_FLOORS-1:0] sw_s1_q, sw_s2_q;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] set_mask, clr_mask;
    logic                  sw_onehot, fault;
    logic                  accept_q, accept_d, reject_q, reject_d;
    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  valid_q, valid_d;
    logic [1:0]            dir_q, dir_d;
    search_t               up_s, down_s;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i      (CLOCK_50),
        .rst_i      (Reset),
        .key_i      (KEY0),
        .press_evt_o(press_evt)
    );

    assign fault     = (32'(cur_floor) >= NUM_FLOORS);
    assign sw_onehot = (sw_s2_q != '0) && ((sw_s2_q & (sw_s2_q - NUM_FLOORS'(1))) == '0);

    assign up_s   = lowest_above(MAX_FLOORS'(pending_q), MAX_W'(cur_floor));
    assign down_s = highest_below(MAX_FLOORS'(pending_q), MAX_W'(cur_floor));

    // Request capture and service; a clear beats a set of the same bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        accept_d = 1'b0;
        reject_d = 1'b0;
        if (press_evt) begin
            if (sw_onehot) begin
                set_mask = sw_s2_q;
                accept_d = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
        if (at_floor && !fault) begin
            clr_mask = NUM_FLOORS'(1) << cur_floor;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (up_s.found)        state_d = S_UP;
                    else if (down_s.found) state_d = S_DOWN;
                end
                S_UP: begin
                    if (!up_s.found) state_d = down_s.found ? S_DOWN : S_IDLE;
                end
                S_DOWN: begin
                    if (!down_s.found) state_d = up_s.found ? S_UP : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Target outputs follow the registered state. Validity tracks the search
    // result so a stale state never advertises a floor with no request.
    always_comb begin
        target_d = cur_floor;
        dir_d    = DIR_IDLE;
        valid_d  = 1'b0;
        if (!fault) begin
            case (state_q)
                S_UP: begin
                    dir_d   = DIR_UP;
                    valid_d = up_s.found;
                    if (up_s.found) target_d = FLOOR_W'(up_s.idx);
                end
                S_DOWN: begin
                    dir_d   = DIR_DOWN;
                    valid_d = down_s.found;
                    if (down_s.found) target_d = FLOOR_W'(down_s.idx);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            pending_q <= '0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            state_q   <= S_IDLE;
            target_q  <= '0;
            valid_q   <= 1'b0;
            dir_q     <= DIR_IDLE;
        end else begin
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            pending_q <= pending_d;
            accept_q  <= accept_d;
            reject_q  <= reject_d;
            state_q   <= state_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
        end
    end

    assign pending      = pending_q;
    assign req_accept   = accept_q;
    assign req_reject   = reject_q;
    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign direction    = dir_q;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Scenario bench for lift_request_scheduler with a short debounce window.
// Each press pushes its expected outcome; a monitor pops and checks it when
// req_accept/req_reject fires.
module tb_lift_request_scheduler;

    logic       clk;
    logic       Reset;
    logic [8:0] SW;
    logic       KEY0;
    logic [3:0] cur_floor;
    logic       at_floor;
    logic [8:0] pending;
    logic [3:0] target_floor;
    logic       target_valid;
    logic [1:0] direction;
    logic       req_accept;
    logic       req_reject;

    typedef struct {
        logic       accept;
        logic [8:0] pend;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   acc_cnt = 0;
    int   rej_cnt = 0;
    logic seen_bit2 = 1'b0;

    lift_request_scheduler #(
        .NUM_FLOORS     (9),
        .FLOOR_W        (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLOCK_50    (clk),
        .Reset       (Reset),
        .SW          (SW),
        .KEY0        (KEY0),
        .cur_floor   (cur_floor),
        .at_floor    (at_floor),
        .pending     (pending),
        .target_floor(target_floor),
        .target_valid(target_valid),
        .direction   (direction),
        .req_accept  (req_accept),
        .req_reject  (req_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!Reset && (req_accept || req_reject)) begin
            if (req_accept) acc_cnt++;
            if (req_reject) rej_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: accept=%b reject=%b pending=%b, required no event",
                         req_accept, req_reject, pending);
            end else begin
                mon_e = exp_q.pop_front();
                if (req_accept !== mon_e.accept || req_reject !== !mon_e.accept ||
                    pending !== mon_e.pend) begin
                    $display("FAIL req_event: accept=%b reject=%b pending=%b, required accept=%b reject=%b pending=%b",
                             req_accept, req_reject, pending, mon_e.accept, !mon_e.accept,
                             mon_e.pend);
                end else begin
                    passes++;
                end
            end
        end
        if (pending[2]) seen_bit2 = 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        KEY0 = 1'b1;
        SW = '0;
        cur_floor = '0;
        at_floor = 1'b0;
        exp_q.delete();
        cycles(2);
        Reset = 1'b0;
        acc_cnt = 0;
        rej_cnt = 0;
        cycles(2);
    endtask

    task automatic start_press(input logic [8:0] sw, input logic acc, input logic [8:0] pend);
        exp_t x;
        SW = sw;
        cycles(3);
        x.accept = acc;
        x.pend = pend;
        exp_q.push_back(x);
        KEY0 = 1'b0;
    endtask

    task automatic release_key();
        cycles(20);
        KEY0 = 1'b1;
        cycles(20);
    endtask

    task automatic press(input logic [8:0] sw, input logic acc, input logic [8:0] pend);
        start_press(sw, acc, pend);
        release_key();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        KEY0 = 1'b1;
        SW = '0;
        cur_floor = 4'd3;
        at_floor = 1'b0;
        cycles(2);
        checks++; if (pending !== 9'b0) $display("FAIL reset_pending: got %b, required 0", pending); else passes++;
        checks++; if (target_floor !== 4'd0) $display("FAIL reset_target: got %0d, required 0", target_floor); else passes++;
        checks++; if (target_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", target_valid); else passes++;
        checks++; if (direction !== 2'd0) $display("FAIL reset_dir: got %0d, required 0", direction); else passes++;
        checks++; if (req_accept !== 1'b0 || req_reject !== 1'b0)
            $display("FAIL reset_pulses: got %b%b, required 00", req_accept, req_reject); else passes++;
        Reset = 1'b0;
        cycles(3);
        // Idle after reset: target follows cur_floor.
        checks++; if (target_floor !== 4'd3 || target_valid !== 1'b0 || direction !== 2'd0)
            $display("FAIL idle_after_reset: got t=%0d v=%b d=%0d, required t=3 v=0 d=0",
                     target_floor, target_valid, direction); else passes++;
    endtask

    task automatic test_bounce();
        int n;
        do_reset();
        SW = 9'b000010000;
        cycles(3);
        for (int i = 0; i < 10; i++) begin
            KEY0 = ~KEY0;
            cycles(3);
        end
        start_press(9'b000010000, 1'b1, 9'b000010000);
        n = 0;
        while (pending === 9'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (pending !== 9'b000010000)
            $display("FAIL bounce_pending: got %b, required 000010000", pending); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (direction !== 2'd1 || target_floor !== 4'd4 || target_valid !== 1'b1)
            $display("FAIL bounce_target: got d=%0d t=%0d v=%b, required d=1 t=4 v=1",
                     direction, target_floor, target_valid); else passes++;
        release_key();
        checks++; if (acc_cnt !== 1 || exp_q.size() !== 0)
            $display("FAIL bounce_accepts: got %0d accepts %0d outstanding, required 1 and 0",
                     acc_cnt, exp_q.size()); else passes++;
    endtask

    task automatic test_invalid_sw();
        do_reset();
        press(9'b100000000, 1'b1, 9'b100000000);
        press(9'b000000110, 1'b0, 9'b100000000);
        press(9'b000000000, 1'b0, 9'b100000000);
        checks++; if (pending !== 9'b100000000)
            $display("FAIL invalid_pending: got %b, required 100000000", pending); else passes++;
        checks++; if (acc_cnt !== 1 || rej_cnt !== 2 || exp_q.size() !== 0)
            $display("FAIL invalid_counts: got acc=%0d rej=%0d outstanding=%0d, required 1 2 0",
                     acc_cnt, rej_cnt, exp_q.size()); else passes++;
    endtask

    task automatic test_scan();
        do_reset();
        cur_floor = 4'd3;
        press(9'b000100000, 1'b1, 9'b000100000);
        press(9'b010000000, 1'b1, 9'b010100000);
        press(9'b000000010, 1'b1, 9'b010100010);
        checks++; if (direction !== 2'd1 || target_floor !== 4'd5 || target_valid !== 1'b1)
            $display("FAIL scan_first: got d=%0d t=%0d v=%b, required d=1 t=5 v=1",
                     direction, target_floor, target_valid); else passes++;
        cur_floor = 4'd5;
        at_floor = 1'b1;
        cycles(4);
        checks++; if (pending !== 9'b010000010 || direction !== 2'd1 || target_floor !== 4'd7)
            $display("FAIL scan_at5: got p=%b d=%0d t=%0d, required p=010000010 d=1 t=7",
                     pending, direction, target_floor); else passes++;
        cur_floor = 4'd7;
        cycles(4);
        checks++; if (pending !== 9'b000000010 || direction !== 2'd2 || target_floor !== 4'd1 ||
                      target_valid !== 1'b1)
            $display("FAIL scan_at7: got p=%b d=%0d t=%0d v=%b, required p=000000010 d=2 t=1 v=1",
                     pending, direction, target_floor, target_valid); else passes++;
        cur_floor = 4'd1;
        cycles(4);
        checks++; if (pending !== 9'b0 || direction !== 2'd0 || target_valid !== 1'b0 ||
                      target_floor !== 4'd1)
            $display("FAIL scan_at1: got p=%b d=%0d t=%0d v=%b, required p=0 d=0 t=1 v=0",
                     pending, direction, target_floor, target_valid); else passes++;
    endtask

    task automatic test_same_floor();
        do_reset();
        cur_floor = 4'd2;
        at_floor = 1'b1;
        cycles(2);
        seen_bit2 = 1'b0;
        press(9'b000000100, 1'b1, 9'b000000000);
        checks++; if (seen_bit2 !== 1'b0)
            $display("FAIL same_floor_bit2: got seen=%b, required 0", seen_bit2); else passes++;
        checks++; if (direction !== 2'd0 || acc_cnt !== 1 || exp_q.size() !== 0)
            $display("FAIL same_floor_state: got d=%0d acc=%0d outstanding=%0d, required 0 1 0",
                     direction, acc_cnt, exp_q.size()); else passes++;
    endtask

    task automatic test_fault_reset();
        do_reset();
        press(9'b100000000, 1'b1, 9'b100000000);
        checks++; if (direction !== 2'd1 || target_floor !== 4'd8)
            $display("FAIL fault_pre: got d=%0d t=%0d, required d=1 t=8", direction, target_floor);
        else passes++;
        cur_floor = 4'd12;
        at_floor = 1'b1;
        cycles(3);
        checks++; if (direction !== 2'd0 || target_valid !== 1'b0 || pending !== 9'b100000000 ||
                      target_floor !== 4'd12)
            $display("FAIL fault_idle: got d=%0d v=%b p=%b t=%0d, required d=0 v=0 p=100000000 t=12",
                     direction, target_valid, pending, target_floor); else passes++;
        SW = 9'b000001000;
        cycles(3);
        KEY0 = 1'b0;
        cycles(6);
        #2;
        Reset = 1'b1;
        KEY0 = 1'b1;
        #1;
        checks++; if (pending !== 9'b0 || target_floor !== 4'd0 || target_valid !== 1'b0 ||
                      direction !== 2'd0 || req_accept !== 1'b0 || req_reject !== 1'b0)
            $display("FAIL async_reset: got p=%b t=%0d v=%b d=%0d a=%b r=%b, required all 0",
                     pending, target_floor, target_valid, direction, req_accept, req_reject);
        else passes++;
        cycles(2);
        cur_floor = '0;
        at_floor = 1'b0;
        Reset = 1'b0;
        cycles(30);
        checks++; if (acc_cnt !== 1 || rej_cnt !== 0 || pending !== 9'b0)
            $display("FAIL no_event_after_reset: got acc=%0d rej=%0d p=%b, required 1 0 0",
                     acc_cnt, rej_cnt, pending); else passes++;
    endtask

    initial begin
        Reset = 1'b1;
        KEY0 = 1'b1;
        SW = '0;
        cur_floor = '0;
        at_floor = 1'b0;
        test_reset();
        test_bounce();
        test_invalid_sw();
        test_scan();
        test_same_floor();
        test_fault_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
